vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Consumes the 25.2 MHz pixel clock and its ready indication from the pixel clock generator. Produces 640x480@60 Hz VGA raster timing:
- pixel coordinates,
- active-low horizontal and vertical sync,
- a visible-region flag,
- line-start and frame-start strobes.

It sits between the pixel clock source and the framebuffer/character renderer, which index video memory with `x_o`/`y_o`.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: hsync pulse width
- `H_BACK`, 48: horizontal back porch
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vsync pulse width
- `V_BACK`, 33: vertical back porch

Ports:
- `clk_pxl_i`, input, 1: pixel clock; the only clock.
- `reset_i`, input, 1: synchronous, active-high reset.
- `enable_i`, input, 1: advance raster when high; hold all state when low. Driven from pixel-clock ready after synchronization.
- `x_o`, output, 10: horizontal counter, 0..799.
- `y_o`, output, 10: vertical counter, 0..524.
- `hsync_o`, output, 1: horizontal sync, active-low.
- `vsync_o`, output, 1: vertical sync, active-low.
- `visible_o`, output, 1: high when x<640 and y<480.
- `line_start_o`, output, 1: one-cycle strobe at x==0.
- `frame_start_o`, output, 1: one-cycle strobe at x==0, y==0.

## Operation
- H_TOTAL = sum of H parameters = 800. V_TOTAL = sum of V parameters = 525. Counters are 10 bits, unsigned.
- Horizontal counter: increments on each enabled edge and wraps H_TOTAL-1 -> 0.
- Vertical counter: increments only on the edge where horizontal wraps, and itself wraps V_TOTAL-1 -> 0.
- Regions, horizontal:
  - visible [0,639]
  - front porch [640,655]
  - sync [656,751]
  - back porch [752,799]
- Regions, vertical:
  - visible [0,479]
  - front porch [480,489]
  - sync [490,491]
  - back porch [492,524]
- `hsync_o` = 0 iff x is in the horizontal sync region. `vsync_o` = 0 iff y is in the vertical sync region. Vsync is decoded purely from y, so it changes at the x wrap.
- Status outputs (`hsync_o`, `vsync_o`, `visible_o`, strobes) are registered decodes of the next-state counter values. They are therefore aligned with `x_o`/`y_o` in the same cycle.
- `enable_i` low:
  - counters and all outputs hold;
  - strobes also hold, so a strobe lasts as long as the raster is stalled at that position.
- Reset values, held for every cycle `reset_i` is sampled high:
  - x_o=0, y_o=0
  - hsync_o=1, vsync_o=1
  - visible_o=0, line_start_o=0, frame_start_o=0

## Timing
- At the first edge with `reset_i` low and `enable_i` high, the counters go to (1,0) and outputs decode (1,0): visible_o=1, hsync_o=1.
- The (0,0) frame_start strobe first occurs after one full frame, 420000 enabled cycles.
- Reset asserted mid-frame: counters and outputs take reset values at that edge. No partial-line completion; no sync glitch beyond a truncated pulse.
- `reset_i` takes priority over `enable_i`.
- Line period 800 enabled cycles; frame period 420000 enabled cycles.
- hsync low for exactly 96 consecutive enabled cycles; vsync low for exactly 1600.

## Configuration
- Macro `VGA_TIMING_LEAD_EN`, defined: `hsync_o`, `vsync_o`, `visible_o`, `line_start_o`, `frame_start_o` pass through a 2-stage enable-gated pipeline.
  - They trail `x_o`/`y_o` by 2 enabled cycles, matching the 2-cycle framebuffer read latency.
  - Pipeline stages reset to the reset values above.
- Not defined: no pipeline; all outputs aligned as specified in Operation.

## Test plan
- Reset held 5 cycles, then released with enable=1 -> x_o steps 1,2,3…; visible_o=1 for x 1..639; visible_o=0 at x=640; line_start_o=1 at x=0 after 799 cycles, with y_o=1.
- Run 800 cycles from line start -> hsync_o=0 exactly for x 656..751 (96 cycles); hsync_o=1 elsewhere.
- Run full frame -> vsync_o=0 only for y 490..491 (1600 cycles); frame_start_o high once per 420000 cycles; y_o wraps 524 -> 0 with x 799 -> 0.
- Toggle enable_i low for 10 cycles at x=655 -> x_o, hsync_o hold; at the next enabled edge x=656 and hsync_o=0.
- Assert reset_i at x=700, y=300 -> next edge x_o=0, y_o=0, hsync_o=1, vsync_o=1, visible_o=0.
- With `VGA_TIMING_LEAD_EN` -> visible_o falls 2 enabled cycles after x_o reaches 640; hsync_o falls when x_o=658.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator.
//
// Ports:
//   clk_pxl_i      pixel clock (25.2 MHz); the only clock
//   reset_i        synchronous active-high reset
//   enable_i       advance the raster when high; hold all state when low
//   x_o, y_o       horizontal (0..H_TOTAL-1) / vertical (0..V_TOTAL-1) counters
//   hsync_o        horizontal sync, active-low
//   vsync_o        vertical sync, active-low
//   visible_o      high inside the visible region
//   line_start_o   strobe while the raster sits at x==0
//   frame_start_o  strobe while the raster sits at x==0, y==0
//
// Build option: define VGA_TIMING_LEAD_EN to delay the status outputs by two
// enabled cycles behind x_o/y_o, which covers the framebuffer read latency.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_pxl_i,
  input  logic       reset_i,
  input  logic       enable_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       visible_o,
  output logic       line_start_o,
  output logic       frame_start_o
);

  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

`ifdef VGA_TIMING_LEAD_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 0;
`endif

  // Status vector layout: {hsync_n, vsync_n, visible, line_start, frame_start}
  localparam logic [4:0] STAT_RST = 5'b11000;

  logic [9:0] x_q, x_d, y_q, y_d;
  logic [4:0] stat_d;
  logic [STAGES:0][4:0] stat_pipe_q;

  // Next raster position; holds when disabled.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (enable_i) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Status is decoded from the next position so that, once registered, it
  // lines up with x_q/y_q in the same cycle.
  always_comb begin
    stat_d    = STAT_RST;
    stat_d[4] = !((x_d >= HS_BEG) && (x_d < HS_END));
    stat_d[3] = !((y_d >= VS_BEG) && (y_d < VS_END));
    stat_d[2] = (x_d < H_VIS) && (y_d < V_VIS);
    stat_d[1] = (x_d == '0);
    stat_d[0] = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk_pxl_i) begin
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Stage 0 is the aligned decode; later stages only advance with the raster,
  // so a stalled raster freezes the whole pipeline (strobes included).
  always_ff @(posedge clk_pxl_i) begin
    if (reset_i) begin
      stat_pipe_q <= {(STAGES+1){STAT_RST}};
    end else if (enable_i) begin
      stat_pipe_q[0] <= stat_d;
      for (int i = 1; i <= STAGES; i++) stat_pipe_q[i] <= stat_pipe_q[i-1];
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign hsync_o       = stat_pipe_q[STAGES][4];
  assign vsync_o       = stat_pipe_q[STAGES][3];
  assign visible_o     = stat_pipe_q[STAGES][2];
  assign line_start_o  = stat_pipe_q[STAGES][1];
  assign frame_start_o = stat_pipe_q[STAGES][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Drives a reduced-geometry instance (frames wrap
// many times within the run) and a default 640x480 instance from shared
// random reset/enable stimulus. Expected outputs come from an enabled-cycle
// count and plain division/modulo over the region boundaries.
module tb_vga_timing_gen;

  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 4;
`ifdef VGA_TIMING_LEAD_EN
  localparam int LEAD = 2;
`else
  localparam int LEAD = 0;
`endif
  localparam int NCYC = 40000;

  logic clk = 1'b0;
  logic rst, en;
  logic [9:0] s_x, s_y, d_x, d_y;
  logic s_hs, s_vs, s_vis, s_ls, s_fs;
  logic d_hs, d_vs, d_vis, d_ls, d_fs;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .clk_pxl_i(clk), .reset_i(rst), .enable_i(en),
    .x_o(s_x), .y_o(s_y), .hsync_o(s_hs), .vsync_o(s_vs),
    .visible_o(s_vis), .line_start_o(s_ls), .frame_start_o(s_fs)
  );

  vga_timing_gen u_full (
    .clk_pxl_i(clk), .reset_i(rst), .enable_i(en),
    .x_o(d_x), .y_o(d_y), .hsync_o(d_hs), .vsync_o(d_vs),
    .visible_o(d_vis), .line_start_o(d_ls), .frame_start_o(d_fs)
  );

  typedef logic [24:0] exp_t; // {x, y, hsync_n, vsync_n, visible, line_start, frame_start}
  exp_t qs[$], qd[$];
  int checks = 0, errors = 0;

  // p = enabled cycles since the last reset edge.
  function automatic exp_t model(int p, int hv, int hf, int hs, int hb,
                                 int vv, int vf, int vs, int vb);
    int ht, vt, sx, sy;
    logic [4:0] st;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (p < LEAD + 1) begin
      st = 5'b11000;
    end else begin
      sx = (p - LEAD) % ht;
      sy = ((p - LEAD) / ht) % vt;
      st = {!(sx >= hv + hf && sx < hv + hf + hs),
            !(sy >= vv + vf && sy < vv + vf + vs),
            (sx < hv) && (sy < vv), sx == 0, (sx == 0) && (sy == 0)};
    end
    return {10'(p % ht), 10'((p / ht) % vt), st};
  endfunction

  task automatic compare(input string name, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d st=%b, expected x=%0d y=%0d st=%b",
               name, got[24:15], got[14:5], got[4:0], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (qs.size() > 0) compare("small", {s_x, s_y, s_hs, s_vs, s_vis, s_ls, s_fs}, qs.pop_front());
    if (qd.size() > 0) compare("full",  {d_x, d_y, d_hs, d_vs, d_vis, d_ls, d_fs}, qd.pop_front());
  end

  initial begin
    int p, burst;
    p = 0;
    burst = 0;
    rst = 1'b1;
    en  = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      if (c < 5) begin
        rst = 1'b1;
        en  = c[0];
      end else if (c < 1700) begin
        rst = 1'b0;
        en  = 1'b1;
      end else begin
        rst = ($urandom_range(0, 4999) == 0) || (c == 20000);
        if (burst > 0) begin
          burst--;
          en = 1'b0;
        end else if ($urandom_range(0, 199) == 0) begin
          burst = 9;
          en = 1'b0;
        end else begin
          en = ($urandom_range(0, 9) != 0);
        end
      end
      @(posedge clk);
      if (rst) p = 0;
      else if (en) p++;
      qs.push_back(model(p, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB));
      qd.push_back(model(p, 640, 16, 96, 48, 480, 10, 2, 33));
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    checks++;
    if (qs.size() != 0 || qd.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", qs.size(), qd.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
